// File: rtl/stage_mix.sv
// Mixer stage: sums one frame of per-voice filtered samples, saturates, applies
// master volume and presents the result on a valid/ready output with sticky status.
module stage_mix #(
   parameter int NUM_VOICES   = 32,
   parameter int SAMPLE_WIDTH = 16,
   parameter int VOLUME_WIDTH = 8
) (
   input  logic                            i_Clock,
   input  logic                            i_Reset_n,
   input  logic                            i_Valid,
   input  logic [$clog2(NUM_VOICES)-1:0]   i_VoiceNum,
   input  logic [SAMPLE_WIDTH-1:0]         i_Sample,
   input  logic [VOLUME_WIDTH-1:0]         i_Volume,
   output logic                            o_Valid,
   input  logic                            i_Ready,
   output logic [SAMPLE_WIDTH-1:0]         o_Sample,
   output logic                            o_Clip,
   output logic                            o_SeqError,
   output logic                            o_Overrun,
   input  logic                            i_ClearFlags
);

   localparam int VNW = $clog2(NUM_VOICES);
   localparam int SW  = SAMPLE_WIDTH;
   localparam int VW  = VOLUME_WIDTH;
   localparam int AW  = SW + VNW;
   localparam int PW  = SW + VW + 1;
   localparam int SHW = PW - (VW - 1);

   localparam logic [SW-1:0] POS_MAX = {1'b0, {(SW-1){1'b1}}};
   localparam logic [SW-1:0] NEG_MAX = {1'b1, {(SW-1){1'b0}}};
   localparam logic [VNW-1:0] LAST_VOICE = VNW'(NUM_VOICES - 1);

   // Frame collector only tracks voice order; SAT and SCALE run as a trailing
   // two-stage pipe so a new frame can start while the previous one finishes.
   typedef enum logic [0:0] {WAIT_START, ACCUM} state_t;

   state_t              state_q, state_d;
   logic signed [AW-1:0] acc_q, acc_d;
   logic [VNW-1:0]      exp_q, exp_d;
   logic [1:0]          vld_pipe_q, vld_pipe_d;
   logic [SW-1:0]       sat_q, sat_d;
   logic                valid_q, valid_d;
   logic [SW-1:0]       sample_q, sample_d;
   logic                clip_q, clip_d;
   logic                seq_q, seq_d;
   logic                ovr_q, ovr_d;

   logic signed [AW-1:0] smp_ext;
   logic                 frame_done;
   logic                 seq_set;

   assign smp_ext = {{VNW{i_Sample[SW-1]}}, i_Sample};

   // ---------------- frame collector ----------------
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      exp_d      = exp_q;
      seq_set    = 1'b0;
      frame_done = 1'b0;
      if (i_Valid) begin
         case (state_q)
            WAIT_START: begin
               if (i_VoiceNum == '0) begin
                  acc_d   = smp_ext;
                  exp_d   = VNW'(1);
                  state_d = ACCUM;
               end else begin
                  seq_set = 1'b1;
               end
            end
            ACCUM: begin
               if (i_VoiceNum == exp_q) begin
                  acc_d = acc_q + smp_ext;
                  exp_d = exp_q + VNW'(1);
                  if (i_VoiceNum == LAST_VOICE) begin
                     state_d    = WAIT_START;
                     frame_done = 1'b1;
                  end
               end else begin
                  seq_set = 1'b1;
                  // An out-of-order voice 0 is treated as the start of a fresh frame.
                  if (i_VoiceNum == '0) begin
                     acc_d = smp_ext;
                     exp_d = VNW'(1);
                  end else begin
                     acc_d   = '0;
                     exp_d   = '0;
                     state_d = WAIT_START;
                  end
               end
            end
            default: state_d = WAIT_START;
         endcase
      end
   end

   // ---------------- SAT stage ----------------
   logic acc_fits;
   logic clip_sat;

   assign acc_fits = (acc_q[AW-1:SW-1] == {(AW-SW+1){acc_q[SW-1]}});
   assign clip_sat = vld_pipe_q[0] & ~acc_fits;

   always_comb begin
      sat_d = sat_q;
      if (vld_pipe_q[0])
         sat_d = acc_fits ? acc_q[SW-1:0] : (acc_q[AW-1] ? NEG_MAX : POS_MAX);
   end

   // ---------------- SCALE stage ----------------
   logic signed [PW-1:0]  prod;
   logic signed [SHW-1:0] shr;
   logic                  scl_fits;
   logic [SW-1:0]         scl_val;
   logic                  clip_scl;

   assign prod     = $signed({{(VW+1){sat_q[SW-1]}}, sat_q}) *
                     $signed({{(SW+1){1'b0}}, i_Volume});
   assign shr      = SHW'(prod >>> (VW - 1));
   assign scl_fits = (shr[SHW-1:SW-1] == {(SHW-SW+1){shr[SW-1]}});
   assign scl_val  = scl_fits ? shr[SW-1:0] : (shr[SHW-1] ? NEG_MAX : POS_MAX);
   assign clip_scl = vld_pipe_q[1] & ~scl_fits;

   assign vld_pipe_d = {vld_pipe_q[0], frame_done};

   // ---------------- output register and sticky flags ----------------
   logic load;
   logic ovr_set;

   assign load    = vld_pipe_q[1];
   assign ovr_set = load & valid_q & ~i_Ready;

   always_comb begin
      valid_d  = load | (valid_q & ~i_Ready);
      sample_d = load ? scl_val : sample_q;
      // A set event in the same cycle as a clear leaves the flag set.
      clip_d   = (clip_q & ~i_ClearFlags) | clip_sat | clip_scl;
      seq_d    = (seq_q  & ~i_ClearFlags) | seq_set;
      ovr_d    = (ovr_q  & ~i_ClearFlags) | ovr_set;
   end

   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q    <= WAIT_START;
         acc_q      <= '0;
         exp_q      <= '0;
         vld_pipe_q <= '0;
         sat_q      <= '0;
         valid_q    <= 1'b0;
         sample_q   <= '0;
         clip_q     <= 1'b0;
         seq_q      <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         exp_q      <= exp_d;
         vld_pipe_q <= vld_pipe_d;
         sat_q      <= sat_d;
         valid_q    <= valid_d;
         sample_q   <= sample_d;
         clip_q     <= clip_d;
         seq_q      <= seq_d;
         ovr_q      <= ovr_d;
      end
   end

   assign o_Valid    = valid_q;
   assign o_Sample   = sample_q;
   assign o_Clip     = clip_q;
   assign o_SeqError = seq_q;
   assign o_Overrun  = ovr_q;

endmodule

// File: tb/tb_stage_mix.sv
// Scoreboard bench for stage_mix with a 4-voice frame: expected mixes are queued
// when a frame is driven and compared as each output transfers.
module tb_stage_mix;
   localparam int NV = 4;
   localparam int SW = 16;
   localparam int VW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_Valid;
   logic [1:0]    i_VoiceNum;
   logic [SW-1:0] i_Sample;
   logic [VW-1:0] i_Volume;
   logic          o_Valid;
   logic          i_Ready;
   logic [SW-1:0] o_Sample;
   logic          o_Clip;
   logic          o_SeqError;
   logic          o_Overrun;
   logic          i_ClearFlags;

   int n_chk = 0;
   int n_err = 0;
   longint sb[$];

   always #5 clk = ~clk;

   stage_mix #(.NUM_VOICES(NV), .SAMPLE_WIDTH(SW), .VOLUME_WIDTH(VW)) dut (
      .i_Clock(clk), .i_Reset_n(rst_n), .i_Valid(i_Valid), .i_VoiceNum(i_VoiceNum),
      .i_Sample(i_Sample), .i_Volume(i_Volume), .o_Valid(o_Valid), .i_Ready(i_Ready),
      .o_Sample(o_Sample), .o_Clip(o_Clip), .o_SeqError(o_SeqError),
      .o_Overrun(o_Overrun), .i_ClearFlags(i_ClearFlags)
   );

   task automatic chk(input string tag, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   function automatic longint clamp16(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic longint mix_model(input longint s0, input longint s1,
                                        input longint s2, input longint s3,
                                        input longint vol);
      longint sat;
      sat = clamp16(s0 + s1 + s2 + s3);
      return clamp16((sat * vol) >>> (VW - 1));
   endfunction

   // Transfer monitor: compare each output that the consumer accepts.
   always @(negedge clk) begin : mon
      longint e;
      if (rst_n && o_Valid && i_Ready) begin
         if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
         else begin
            e = sb.pop_front();
            chk("mix_out", $signed(o_Sample), e);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send(input int v, input int s);
      i_Valid    = 1'b1;
      i_VoiceNum = 2'(v);
      i_Sample   = 16'(s);
      tick();
      i_Valid    = 1'b0;
   endtask

   task automatic frame(input int s0, input int s1, input int s2, input int s3, input int gap);
      sb.push_back(mix_model(s0, s1, s2, s3, longint'(i_Volume)));
      send(0, s0); idle(gap);
      send(1, s1); idle(gap);
      send(2, s2); idle(gap);
      send(3, s3);
   endtask

   task automatic clr();
      i_ClearFlags = 1'b1;
      tick();
      i_ClearFlags = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
      $fatal(1);
   end

   initial begin
      i_Valid = 0; i_VoiceNum = 0; i_Sample = 0; i_Volume = 8'd128;
      i_Ready = 1; i_ClearFlags = 0;
      #12;
      chk("rst_valid", o_Valid, 0);
      chk("rst_sample", o_Sample, 0);
      chk("rst_clip", o_Clip, 0);
      chk("rst_seq", o_SeqError, 0);
      chk("rst_ovr", o_Overrun, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      tick();

      // basic mix and latency
      frame(100, 200, -50, 25, 0);
      chk("lat_n0", o_Valid, 0);
      tick(); chk("lat_n1", o_Valid, 0);
      tick(); chk("lat_n2", o_Valid, 1);
      chk("t1_sample", $signed(o_Sample), 275);
      chk("t1_clip", o_Clip, 0);
      chk("t1_seq", o_SeqError, 0);
      chk("t1_ovr", o_Overrun, 0);
      idle(2);

      // saturation in both stages
      frame(32767, 32767, 32767, 32767, 0); idle(3);
      chk("sat_clip", o_Clip, 1);
      clr();
      chk("clip_cleared", o_Clip, 0);
      i_Volume = 8'd255;
      frame(20000, 0, 0, 0, 0); idle(3);
      chk("scale_clip", o_Clip, 1);
      i_Volume = 8'd64;
      frame(-100, 0, 0, 0, 0); idle(3);
      i_Volume = 8'd128;

      // sequence errors
      clr();
      send(2, 5);
      chk("seq_wait_start", o_SeqError, 1);
      clr();
      chk("seq_cleared", o_SeqError, 0);
      send(0, 1); send(1, 2); send(3, 4); idle(4);
      chk("seq_skip", o_SeqError, 1);
      chk("seq_no_out", o_Valid, 0);
      frame(1, 2, 3, 4, 0); idle(3);
      clr();
      send(0, 999); send(1, 999);
      frame(10, 20, 30, 40, 0); idle(3);
      chk("seq_restart", o_SeqError, 1);

      // overrun with consumer stalled
      clr();
      i_Ready = 1'b0;
      frame(1000, 1, 1, 1, 0);
      frame(-7, -7, -7, -7, 0);
      idle(2);
      chk("ovr_valid", o_Valid, 1);
      chk("ovr_sample", $signed(o_Sample), -28);
      chk("ovr_flag", o_Overrun, 1);
      void'(sb.pop_front());
      i_Ready = 1'b1;
      tick();
      i_Ready = 1'b0;
      chk("ovr_drain", o_Valid, 0);

      // transfer and load in the same cycle
      clr();
      frame(300, 0, 0, 0, 0); idle(3);
      chk("sc_first_valid", o_Valid, 1);
      frame(0, 0, 0, -300, 0);
      tick();
      i_Ready = 1'b1;
      tick();
      chk("sc_hold_valid", o_Valid, 1);
      chk("sc_new_sample", $signed(o_Sample), -300);
      tick();
      chk("sc_drained", o_Valid, 0);
      chk("sc_no_ovr", o_Overrun, 0);

      // idle gaps between voices, clear colliding with clip
      frame(100, 200, -50, 25, 3); idle(3);
      clr();
      chk("pre_clip", o_Clip, 0);
      frame(32767, 32767, 32767, 32767, 0);
      i_ClearFlags = 1'b1;
      tick();
      i_ClearFlags = 1'b0;
      chk("clr_vs_clip", o_Clip, 1);
      idle(3);

      // async reset mid-frame
      send(0, 30000); send(1, 30000);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_clip", o_Clip, 0);
      chk("rst_mid_valid", o_Valid, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      tick();

      // async reset with output pending
      i_Ready = 1'b0;
      frame(5, 5, 5, 5, 0); idle(3);
      chk("rst_pend_pre", o_Valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_pend_valid", o_Valid, 0);
      chk("rst_pend_sample", o_Sample, 0);
      sb.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      i_Ready = 1'b1;
      tick();
      frame(7, 8, 9, 10, 0);
      idle(2);
      chk("post_rst_valid", o_Valid, 1);
      chk("post_rst_sample", $signed(o_Sample), 34);
      chk("post_rst_seq", o_SeqError, 0);

      for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
      chk("sb_drain", sb.size(), 0);
      idle(2);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/stage_mix.md
Name: stage_mix

Overview:
- Pipeline stage directly downstream of stage_filter.
- Consumes one filtered sample per voice, in voice order 0..NUM_VOICES-1. Sums each complete frame into one output sample.
- Saturates the sum, applies master volume, then presents the result on a valid/ready interface to the audio output serializer.
- Reports clipping, sequence errors and output overrun as sticky flags.

Parameters:
NUM_VOICES, 32, voices per sample frame (power of two, >=2)
SAMPLE_WIDTH, 16, signed sample width in and out
VOLUME_WIDTH, 8, unsigned master volume width; unity gain = 2^(VOLUME_WIDTH-1)

Ports:
i_Clock  in  1  system clock, all logic on rising edge
i_Reset_n  in  1  asynchronous active-low reset
i_Valid  in  1  filter sample valid (no backpressure to filter)
i_VoiceNum  in  clog2(NUM_VOICES)  voice index of i_Sample
i_Sample  in  SAMPLE_WIDTH  signed filtered sample
i_Volume  in  VOLUME_WIDTH  unsigned master volume
o_Valid  out  1  output sample valid
i_Ready  in  1  consumer accepts o_Sample when o_Valid&&i_Ready
o_Sample  out  SAMPLE_WIDTH  signed mixed sample
o_Clip  out  1  sticky: saturation occurred
o_SeqError  out  1  sticky: voice order violated
o_Overrun  out  1  sticky: unconsumed output overwritten
i_ClearFlags  in  1  one-cycle pulse clears sticky flags

Behaviour:
- Reset (async assert, sync release): state WAIT_START, accumulator 0, expected voice 0, all outputs 0.
- Accumulator width: SAMPLE_WIDTH+clog2(NUM_VOICES), signed. A full frame never overflows the accumulator.
- States:
  - WAIT_START: i_Valid with voice 0 loads acc=sample, expected=1, go to ACCUM. Valid with any other voice sets o_SeqError and stays in WAIT_START.
  - ACCUM: i_Valid with voice==expected gives acc+=sample, expected++.
    - If that voice is NUM_VOICES-1, go to SAT.
    - If voice!=expected: set o_SeqError and discard the frame. If the offending voice is 0, restart the frame with it (acc=sample, expected=1). Otherwise go to WAIT_START.
    - Cycles with i_Valid low hold all state.
  - SAT (1 cycle): clamp acc to [-2^(SW-1), 2^(SW-1)-1] into a registered value. Set o_Clip if clamped. Go to SCALE.
  - SCALE (1 cycle): product = sat * i_Volume (unsigned volume), arithmetic shift right by VOLUME_WIDTH-1, clamp to SAMPLE_WIDTH (set o_Clip if clamped), load output register, go to WAIT_START.
- i_Volume is sampled only in SCALE.
- Latency: last voice accepted on cycle N gives o_Valid high on cycle N+2 (visible after edge N+2).
- Filter input during SAT/SCALE: if i_Valid is high, treat it as WAIT_START input. Voice 0 starts a new frame with no lost sample; any other voice is a sequence error.
- Output handshake:
  - o_Valid stays high and o_Sample holds until i_Ready.
  - Transfer occurs on o_Valid&&i_Ready; o_Valid then drops unless a new result loads that same cycle.
  - New result with o_Valid&&!i_Ready: overwrite o_Sample and set o_Overrun.
  - New result with o_Valid&&i_Ready: old sample transfers, new one loads, o_Valid stays 1, no overrun.
- Sticky flags: i_ClearFlags clears all three. A set event in the same cycle wins (flag stays 1).
- Reset mid-frame drops the partial sum and any pending output, with o_Valid=0 immediately.

Test Plan:
- NUM_VOICES=4, volume 128, i_Ready=1, samples 100,200,-50,25 back-to-back -> o_Valid 2 cycles after last, o_Sample=275, no flags.
- Four samples of 32767, volume 128 -> o_Sample=32767, o_Clip=1. Then volume 255 with samples 20000,0,0,0 -> 32767 (second clamp), o_Clip=1. Then samples -100,0,0,0, volume 64 -> -50.
- Voices 0,1,3 -> o_SeqError=1, no output. Then a clean frame 0..3 -> correct sum. Voices 0,1,0,1,2,3 -> frame restarts at the second 0, one output produced.
- i_Ready=0, two complete frames -> o_Sample equals the second sum, o_Overrun=1. Raise i_Ready one cycle -> o_Valid=0 next cycle. Repeat with i_Ready=1 on the load cycle -> no overrun.
- i_Valid gaps of 3 idle cycles between voices -> same sum as back-to-back. i_ClearFlags together with a clip event -> o_Clip stays 1.
- Assert i_Reset_n low asynchronously mid-frame and with o_Valid=1 -> outputs 0 immediately. After release, a clean frame produces the correct sum, unaffected by the prior partial frame.
